multiplier_control: RTL and testbench
=====================================

// Module: multiplier_control
// PURPOSE
//   Control FSM sequencing the 8-bit signed shift-add multiplier datapath (register unit + 9-bit adder).
//   Generates load/clear/shift/add/subtract strobes from the operator Run and ClearA_LoadB inputs,
//     with M = B[0] fed back.
//   Performs N add-then-shift iterations; the last iteration subtracts (two's-complement multiplier MSB).
//   Sits between the switch/button synchronisers and the register unit / adder.
// PARAMETERS
//   N_BITS   8   operand width = number of add/shift iterations (>=2)
// PORTS
//   Clk           in   1  system clock; all state changes on rising edge
//   Reset         in   1  synchronous, active-high reset
//   Run           in   1  start request, level (synchronised button); must drop before the next run
//   ClearA_LoadB  in   1  load B from switches and clear X:A; honoured only in IDLE
//   M             in   1  current multiplier LSB (B[0]), sampled combinationally in ADD
//   Clr_XA        out  1  clear X and A to 0 next edge
//   Ld_B          out  1  load B from D next edge
//   Ld_XA         out  1  load X:A from adder result next edge
//   Shift_En      out  1  arithmetic-shift X:A:B right by one
//   Fn            out  1  adder function: 0 = A+S, 1 = A-S
//   Busy          out  1  high from CLR through the last SHIFT
//   Done          out  1  high in HOLD
// BEHAVIOUR
//   State regs: state (IDLE, CLR, ADD, SHIFT, HOLD); cnt ($clog2(N_BITS) bits).
//   Outputs: pure decode of state, cnt and M (Mealy on M in ADD only); no output registers.
//   Reset (any state, any cycle): state<=IDLE, cnt<=0; next cycle all outputs 0 except as IDLE decodes.
//   Mid-operation reset aborts; datapath contents undefined, no Done.
//   IDLE:  Busy=0, Done=0.
//     Run=1 -> CLR.
//     Else if ClearA_LoadB=1: Ld_B=1 and Clr_XA=1 this cycle; stay IDLE.
//     Run and ClearA_LoadB both high: Run wins; no Ld_B.
//   CLR:   Clr_XA=1, Busy=1; cnt<=0 -> ADD.
//   ADD:   Busy=1; Ld_XA=M; Fn=1 iff cnt==N_BITS-1 (else 0); -> SHIFT.
//     M=0: no strobes, the cycle still elapses (fixed latency).
//   SHIFT: Shift_En=1, Busy=1.
//     cnt==N_BITS-1 -> HOLD, cnt<=0.
//     Else cnt<=cnt+1 -> ADD.
//   HOLD:  Done=1, Busy=0; all strobes 0.
//     Run=0 -> IDLE; Run=1 -> stay (one multiply per press).
//   Strobes are mutually exclusive except Ld_B+Clr_XA in IDLE; never Ld_XA and Shift_En together.
//   Latency: Run seen at edge k -> CLR during cycle k+1; first ADD k+2; HOLD entered at edge k+1+2*N_BITS
//     (k+17 for N=8).
//   Run dropping during CLR/ADD/SHIFT is ignored; the operation completes.
//   ClearA_LoadB outside IDLE is ignored (no Ld_B, no Clr_XA).
//   cnt never exceeds N_BITS-1; no wrap reachable.
// TESTING
//   1 Reset held 3 cycles in any state -> IDLE, Busy=Done=0, all strobes 0 on the cycle after release.
//   2 IDLE, ClearA_LoadB=1 one cycle -> exactly one cycle of Ld_B=1 and Clr_XA=1; state stays IDLE.
//   3 M from a B=0x07 model (7*-3 with S=0xFD) -> Ld_XA pulses in ADD iterations 0,1,2 only, Fn=0.
//     8 Shift_En pulses; Done at edge k+17; X:A:B = 0xFFEB.
//   4 B=0x80 model (-128) -> single Ld_XA in iteration 7 with Fn=1; Busy exactly 17 cycles.
//   5 Run held high after Done -> stays HOLD for 20 cycles, no second CLR.
//     Run drops -> IDLE next edge; re-press runs again.
//   6 Run and ClearA_LoadB simultaneous in IDLE -> CLR, no Ld_B.
//     Reset asserted in SHIFT iteration 4 -> IDLE, cnt 0, no Done.

Source files
------------

// File: rtl/multiplier_control.sv
// Control sequencer for the signed shift-add multiplier.
// Walks CLR -> (ADD, SHIFT) x N_BITS -> HOLD and decodes the datapath strobes
// directly from state, iteration count and the fed-back multiplier LSB M.
module multiplier_control #(
    parameter int N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Ld_XA,
    output logic Shift_En,
    output logic Fn,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(N_BITS);
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Next-state and iteration counter; Run is only looked at in IDLE and HOLD,
    // so releasing the button mid-operation never aborts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:  if (Run) state_d = CLR;
            CLR: begin
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD:   state_d = SHIFT;
            SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            HOLD:  if (!Run) state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; the final iteration subtracts because the multiplier MSB
    // carries negative weight in two's complement.
    always_comb begin
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Ld_XA    = 1'b0;
        Shift_En = 1'b0;
        Fn       = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Run has priority: a simultaneous load request is dropped.
                if (!Run && ClearA_LoadB) begin
                    Ld_B   = 1'b1;
                    Clr_XA = 1'b1;
                end
            end
            CLR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            ADD: begin
                Busy  = 1'b1;
                Ld_XA = M;
                Fn    = (cnt_q == LAST);
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            HOLD:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: a small register-unit model closes the M loop,
// stimulus pushes the per-cycle expected strobe trace derived from the operand
// bits, and a monitor pops and compares every cycle.
module tb_multiplier_control;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clr_XA, Ld_B, Ld_XA, Shift_En, Fn, Busy, Done;

    logic [7:0] D;
    logic       X = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;

    typedef struct {
        logic [6:0]  o;
        bit          chk;
        logic [15:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    multiplier_control #(.N_BITS(N)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Ld_XA(Ld_XA), .Shift_En(Shift_En),
        .Fn(Fn), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    assign M = B[0];

    // Register unit + 9-bit adder driven by the DUT strobes; D doubles as S.
    always @(posedge Clk) begin
        if (Clr_XA) begin
            X <= 1'b0;
            A <= 8'h00;
        end
        if (Ld_B) B <= D;
        if (Ld_XA) {X, A} <= Fn ? ({A[7], A} - {D[7], D}) : ({A[7], A} + {D[7], D});
        if (Shift_En) {X, A, B} <= {X, X, A, B[7:1]};
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Monitor: order {Clr_XA, Ld_B, Ld_XA, Shift_En, Fn, Busy, Done}.
    always @(negedge Clk) begin
        logic [6:0] outs;
        exp_t       e;
        outs = {Clr_XA, Ld_B, Ld_XA, Shift_En, Fn, Busy, Done};
        if (!Reset) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("trace", {9'd0, outs}, {9'd0, e.o});
                if (e.chk) check("product", {A, B}, e.p);
            end else begin
                // Idle: only a lone load request produces strobes.
                check("idle", {9'd0, outs},
                      {9'd0, {2{ClearA_LoadB & ~Run}}, 5'b00000});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One multiply: load B, then press Run for r cycles. abort_at >= 0 applies
    // a 3-cycle reset at that cycle offset (0 = the Run-press cycle).
    task automatic run_op(input logic [7:0] b, input logic [7:0] s, input int r,
                          input int abort_at, input bit both);
        int   hold, total, pr;
        exp_t e;
        D = b; ClearA_LoadB = 1'b1; Run = 1'b0;
        tick();
        ClearA_LoadB = 1'b0; D = s;
        tick();
        hold  = (r > 18) ? r - 17 : 1;
        total = 18 + hold;
        pr    = $signed(s) * $signed(b);
        e.chk = 1'b0; e.p = '0;
        e.o = 7'b0000000; exp_q.push_back(e);
        e.o = 7'b1000010; exp_q.push_back(e);
        for (int i = 0; i < N; i++) begin
            e.o = {2'b00, b[i], 1'b0, (i == N - 1), 1'b1, 1'b0}; exp_q.push_back(e);
            e.o = 7'b0001010; exp_q.push_back(e);
        end
        for (int h = 0; h < hold; h++) begin
            e.o = 7'b0000001; e.chk = (h == 0); e.p = pr[15:0];
            exp_q.push_back(e);
        end
        for (int cyc = 0; cyc < total; cyc++) begin
            Run = (cyc < r);
            ClearA_LoadB = (cyc == 0) ? both : 1'($urandom_range(0, 1));
            if (cyc == abort_at) begin
                Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0;
                exp_q.delete();
                repeat (3) tick();
                Reset = 1'b0;
                return;
            end
            tick();
        end
        Run = 1'b0; ClearA_LoadB = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; D = 8'h00;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        // Lone load requests in IDLE.
        for (int i = 0; i < 6; i++) begin
            ClearA_LoadB = 1'($urandom_range(0, 1));
            tick();
        end
        ClearA_LoadB = 1'b0;
        run_op(8'h07, 8'hFD, 1, -1, 1'b0);            // 7 * -3 = 0xFFEB
        run_op(8'h80, 8'($urandom), 4, -1, 1'b0);     // -128: single subtract
        run_op(8'($urandom), 8'($urandom), 40, -1, 1'b0); // long hold
        run_op(8'($urandom), 8'($urandom), 3, -1, 1'b1);  // Run + load together
        run_op(8'hA5, 8'h3C, 2, 11, 1'b0);            // reset in SHIFT iter 4
        run_op(8'h07, 8'hFD, 1, -1, 1'b0);            // clean run after abort
        for (int k = 0; k < 20; k++)
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(1, 25)), -1, 1'b0);
        run_op(8'h7F, 8'h80, 1, -1, 1'b0);
        run_op(8'h80, 8'h80, 1, -1, 1'b0);
        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
